// File: rtl/prescaled_updown_counter_pkg.sv
// Shared constants for the prescaled up/down counter slice.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter
//   DEFAULT_WIDTH        : default count register width
//   DEFAULT_PS_W         : default prescaler divider width
package prescaled_updown_counter_pkg;

    localparam int unsigned MODE_WRAP     = 0;
    localparam int unsigned MODE_SAT      = 1;
    localparam int unsigned DEFAULT_WIDTH = 24;
    localparam int unsigned DEFAULT_PS_W  = 8;

endpackage

// File: rtl/clk_prescaler.sv
// Enable-gated down-counting prescaler.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; clears the prescaler to 0
//   en     : advance the prescaler this clock
//   div    : reload value; a tick occurs every div+1 enabled clocks
//   reload : force a reload of div (takes priority over counting)
//   tick   : high while en=1 and the prescaler sits at 0
module clk_prescaler
    import prescaled_updown_counter_pkg::*;
#(
    parameter int unsigned PS_W = DEFAULT_PS_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [PS_W-1:0] div,
    input  logic            reload,
    output logic            tick
);

    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;

    always_comb begin
        ps_d = ps_q;
        if (reload) begin
            ps_d = div;
        end else if (en) begin
            ps_d = (ps_q == '0) ? div : ps_q - PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    assign tick = en && (ps_q == '0);

endmodule

// File: rtl/prescaled_updown_counter.sv
// Prescaled up/down counter with programmable terminal value.
//   clk      : rising-edge clock
//   reset    : synchronous, active-high
//   en       : count enable (gates prescaler and steps)
//   up       : 1 = increment, 0 = decrement
//   div      : prescale value, one step per div+1 enabled clocks
//   max_val  : inclusive upper count limit
//   load     : synchronous load strobe (beats a step in the same clock)
//   load_val : value loaded, clamped to max_val
//   count    : registered count
//   tc       : one-clock pulse following a step taken at a limit
//   at_zero  : registered count == 0 (lags count by one clock)
//   at_max   : registered count == max_val (lags count by one clock)
module prescaled_updown_counter
    import prescaled_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned PS_W     = DEFAULT_PS_W,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic [PS_W-1:0]  div,
    input  logic [WIDTH-1:0] max_val,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_zero,
    output logic             at_max
);

    localparam bit SAT = (SATURATE == MODE_SAT);

    logic             tick;
    logic             step;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             at_zero_q, at_zero_d;
    logic             at_max_q, at_max_d;

    clk_prescaler #(
        .PS_W (PS_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .div    (div),
        .reload (load),
        .tick   (tick)
    );

    assign step = tick && !load;

    always_comb begin
        count_d   = count_q;
        tc_d      = 1'b0;
        at_zero_d = (count_q == '0);
        at_max_d  = (count_q == max_val);
        if (load) begin
            count_d = (load_val > max_val) ? max_val : load_val;
        end else if (step) begin
            if (up) begin
                if (count_q >= max_val) begin
                    count_d = SAT ? max_val : '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = SAT ? '0 : max_val;
                    tc_d    = 1'b1;
                end else if (SAT && (count_q > max_val)) begin
                    // Above the limit (max_val lowered at runtime): snap back.
                    count_d = max_val;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            tc_q      <= 1'b0;
            at_zero_q <= 1'b1;
            at_max_q  <= (max_val == '0);
        end else begin
            count_q   <= count_d;
            tc_q      <= tc_d;
            at_zero_q <= at_zero_d;
            at_max_q  <= at_max_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign at_zero = at_zero_q;
    assign at_max  = at_max_q;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Bench for prescaled_updown_counter: three instances sharing stimulus
// (8-bit wrap, 8-bit saturate, 4-bit wrap) checked against a reference
// model through a scoreboard queue, plus a directed vector table and
// hand-written corner sequences.
module tb_prescaled_updown_counter;

    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [3:0] div;
    logic [7:0] max_val, load_val;

    logic [7:0] count_a, count_b;
    logic [3:0] count_c;
    logic       tc_a, tc_b, tc_c;
    logic       at_zero_a, at_zero_b, at_zero_c;
    logic       at_max_a, at_max_b, at_max_c;

    always #5 clk = ~clk;

    prescaled_updown_counter #(.WIDTH(8), .PS_W(4), .SATURATE(0)) u_dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .div(div),
        .max_val(max_val), .load(load), .load_val(load_val),
        .count(count_a), .tc(tc_a), .at_zero(at_zero_a), .at_max(at_max_a)
    );

    prescaled_updown_counter #(.WIDTH(8), .PS_W(4), .SATURATE(1)) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .div(div),
        .max_val(max_val), .load(load), .load_val(load_val),
        .count(count_b), .tc(tc_b), .at_zero(at_zero_b), .at_max(at_max_b)
    );

    prescaled_updown_counter #(.WIDTH(4), .PS_W(4), .SATURATE(0)) u_dut_c (
        .clk(clk), .reset(reset), .en(en), .up(up), .div(div),
        .max_val(max_val[3:0]), .load(load), .load_val(load_val[3:0]),
        .count(count_c), .tc(tc_c), .at_zero(at_zero_c), .at_max(at_max_c)
    );

    typedef struct {
        int unsigned dut;
        int unsigned cnt;
        bit          tc;
        bit          az;
        bit          am;
    } exp_t;

    typedef struct {
        bit          rst;
        bit          en;
        bit          up;
        bit          ld;
        int unsigned dv;
        int unsigned mx;
        int unsigned lv;
        int unsigned ecnt;
        bit          etc;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[29];
    int unsigned tests = 0;
    int unsigned fails = 0;

    int unsigned m_cnt[3];
    int unsigned m_ps[3];
    bit          m_tc[3];
    bit          m_az[3];
    bit          m_am[3];

    function automatic int unsigned width_of(input int unsigned d);
        return (d == 2) ? 4 : 8;
    endfunction

    function automatic bit sat_of(input int unsigned d);
        return (d == 1);
    endfunction

    // Reference model: advance every instance by one clock edge using the
    // inputs currently driven, and queue the expected outputs.
    task automatic model_edge();
        for (int unsigned d = 0; d < 3; d++) begin
            int unsigned mask;
            int unsigned mx;
            int unsigned lv;
            int unsigned old;
            exp_t        e;
            mask = (1 << width_of(d)) - 1;
            mx   = max_val & mask;
            lv   = load_val & mask;
            old  = m_cnt[d];
            if (reset) begin
                m_cnt[d] = 0;
                m_ps[d]  = 0;
                m_tc[d]  = 0;
                m_az[d]  = 1;
                m_am[d]  = (mx == 0);
            end else begin
                m_az[d] = (old == 0);
                m_am[d] = (old == mx);
                m_tc[d] = 0;
                if (load) begin
                    m_cnt[d] = (lv < mx) ? lv : mx;
                    m_ps[d]  = div;
                end else if (en) begin
                    if (m_ps[d] == 0) begin
                        m_ps[d] = div;
                        if (up) begin
                            if (old >= mx) begin
                                m_cnt[d] = sat_of(d) ? mx : 0;
                                m_tc[d]  = 1;
                            end else begin
                                m_cnt[d] = old + 1;
                            end
                        end else begin
                            if (old == 0) begin
                                m_cnt[d] = sat_of(d) ? 0 : mx;
                                m_tc[d]  = 1;
                            end else if (sat_of(d) && old > mx) begin
                                m_cnt[d] = mx;
                            end else begin
                                m_cnt[d] = old - 1;
                            end
                        end
                    end else begin
                        m_ps[d] = m_ps[d] - 1;
                    end
                end
            end
            e.dut = d;
            e.cnt = m_cnt[d];
            e.tc  = m_tc[d];
            e.az  = m_az[d];
            e.am  = m_am[d];
            sb.push_back(e);
        end
    endtask

    task automatic get_act(input int unsigned d, output int unsigned c,
                           output bit t, output bit z, output bit m);
        case (d)
            0:       begin c = count_a; t = tc_a; z = at_zero_a; m = at_max_a; end
            1:       begin c = count_b; t = tc_b; z = at_zero_b; m = at_max_b; end
            default: begin c = count_c; t = tc_c; z = at_zero_c; m = at_max_c; end
        endcase
    endtask

    task automatic check_sb();
        while (sb.size() > 0) begin
            exp_t        e;
            int unsigned c;
            bit          t, z, m;
            e = sb.pop_front();
            get_act(e.dut, c, t, z, m);
            tests++;
            if (c != e.cnt || t != e.tc || z != e.az || m != e.am) begin
                fails++;
                $display("FAIL model dut%0d @%0t: count/tc/at_zero/at_max got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                         e.dut, $time, c, t, z, m, e.cnt, e.tc, e.az, e.am);
            end
        end
    endtask

    task automatic expect_val(input string name, input int unsigned act,
                              input int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_sb();
    endtask

    task automatic drive(input bit r, input bit e, input bit u, input bit l,
                         input int unsigned dv, input int unsigned mx,
                         input int unsigned lv);
        reset    = r;
        en       = e;
        up       = u;
        load     = l;
        div      = 4'(dv);
        max_val  = 8'(mx);
        load_val = 8'(lv);
    endtask

    initial begin
        // rst en up ld div max lv | count tc  (for the 8-bit wrap instance)
        tbl[0]  = '{1, 0, 1, 0, 0,  5,   0,  0, 0};
        tbl[1]  = '{0, 1, 1, 0, 0,  5,   0,  1, 0};
        tbl[2]  = '{0, 1, 1, 0, 0,  5,   0,  2, 0};
        tbl[3]  = '{0, 1, 1, 0, 0,  5,   0,  3, 0};
        tbl[4]  = '{0, 1, 1, 0, 0,  5,   0,  4, 0};
        tbl[5]  = '{0, 1, 1, 0, 0,  5,   0,  5, 0};
        tbl[6]  = '{0, 1, 1, 0, 0,  5,   0,  0, 1};
        tbl[7]  = '{0, 1, 1, 0, 0,  5,   0,  1, 0};
        tbl[8]  = '{0, 0, 1, 1, 0, 50, 100, 50, 0};
        tbl[9]  = '{0, 1, 1, 1, 0, 50,  10, 10, 0};
        tbl[10] = '{0, 1, 1, 0, 0, 50,   0, 11, 0};
        tbl[11] = '{0, 1, 0, 0, 0, 50,   0, 10, 0};
        tbl[12] = '{0, 1, 0, 0, 3, 50,   0,  9, 0};
        tbl[13] = '{0, 1, 0, 0, 3, 50,   0,  9, 0};
        tbl[14] = '{0, 1, 0, 0, 3, 50,   0,  9, 0};
        tbl[15] = '{0, 1, 0, 0, 3, 50,   0,  9, 0};
        tbl[16] = '{0, 1, 0, 0, 3, 50,   0,  8, 0};
        tbl[17] = '{0, 0, 0, 0, 3, 50,   0,  8, 0};
        tbl[18] = '{0, 0, 0, 0, 3, 50,   0,  8, 0};
        tbl[19] = '{0, 1, 0, 0, 3, 50,   0,  8, 0};
        tbl[20] = '{0, 1, 0, 0, 3, 50,   0,  8, 0};
        tbl[21] = '{0, 1, 0, 0, 3, 50,   0,  8, 0};
        tbl[22] = '{0, 1, 0, 0, 3, 50,   0,  7, 0};
        tbl[23] = '{0, 1, 0, 0, 3, 50,   0,  7, 0};
        tbl[24] = '{1, 1, 0, 1, 3, 50,  20,  0, 0};
        tbl[25] = '{0, 1, 1, 0, 0, 50,   0,  1, 0};
        tbl[26] = '{0, 1, 0, 0, 0, 50,   0,  0, 0};
        tbl[27] = '{0, 1, 0, 0, 0, 50,   0, 50, 1};
        tbl[28] = '{0, 0, 0, 0, 0, 50,   0, 50, 0};

        for (int unsigned d = 0; d < 3; d++) begin
            m_cnt[d] = 0;
            m_ps[d]  = 0;
            m_tc[d]  = 0;
            m_az[d]  = 1;
            m_am[d]  = 0;
        end
        drive(1, 0, 0, 0, 0, 5, 0);

        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].ld,
                  tbl[i].dv, tbl[i].mx, tbl[i].lv);
            cycle();
            expect_val($sformatf("vec%0d_count", i), count_a, tbl[i].ecnt);
            expect_val($sformatf("vec%0d_tc", i), tc_a, tbl[i].etc);
        end
        expect_val("reset_at_zero_after_vec", at_zero_a, 0);

        // Saturating down-count pinned at zero: tc every clock.
        drive(0, 0, 0, 1, 0, 50, 0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 0, 50, 0);
            cycle();
            expect_val("sat_zero_count", count_b, 0);
            expect_val("sat_zero_tc", tc_b, 1);
            expect_val("sat_zero_at_zero", at_zero_b, 1);
        end

        // max_val = 0: every step is a limit step.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 0, 0, 0);
            cycle();
            expect_val("max0_count", count_a, 0);
            expect_val("max0_tc", tc_a, 1);
        end

        // 4-bit instance wrapping down from 0 to 15.
        drive(0, 0, 0, 1, 0, 15, 0);
        cycle();
        drive(0, 1, 0, 0, 0, 15, 0);
        cycle();
        expect_val("w4_wrap_count", count_c, 15);
        expect_val("w4_wrap_tc", tc_c, 1);

        // Load clamp, then at_max one clock later.
        drive(0, 0, 1, 1, 0, 50, 100);
        cycle();
        expect_val("clamp_count", count_a, 50);
        drive(0, 0, 1, 0, 0, 50, 0);
        cycle();
        expect_val("clamp_at_max", at_max_a, 1);

        // Random stimulus against the model.
        max_val = 8'd20;
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 49) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 15) == 0);
            div      = 4'($urandom_range(0, 3));
            load_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 31) == 0) begin
                max_val = 8'($urandom_range(0, 255));
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
